enoc_netemu_bridge: RTL and testbench

Parametrised bridge between the NetEmulation packet interface (valid carried inside packet_t, net_full backpressure) and the ENoC_Network valid/enable interface.
- Generalises the plain wrap to any X_NODES x Y_NODES mesh; non-square meshes are allowed.
- Adds a per-node ingress FIFO with threshold-based net_full, and a registered egress stage.
- Sits beside ENoC_Network inside the NetEmulation top; the top instantiates both blocks.

---
 rtl/enoc_netemu_bridge_pkg.sv | 20 ++
 rtl/enoc_ingress_fifo.sv | 75 +++++++
 rtl/enoc_netemu_bridge.sv | 102 ++++++++++
 tb/tb_enoc_netemu_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enoc_netemu_bridge_pkg.sv
// rtl/enoc_netemu_bridge_pkg.sv - packet type and sizing helpers shared by the NetEmulation/ENoC bridge
package enoc_netemu_bridge_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  source;
    logic [7:0]  dest;
    logic        valid;
  } packet_t;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy must represent DEPTH itself, hence one more code point than the pointers.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/enoc_ingress_fifo.sv
// rtl/enoc_ingress_fifo.sv - per-node show-ahead ingress FIFO with occupancy threshold and drop flag
module enoc_ingress_fifo
  import enoc_netemu_bridge_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int THRESH = DEPTH - 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  packet_t data_i,
  input  logic    pop_i,
  output packet_t head_o,
  output logic    val_o,
  output logic    full_thresh_o,
  output logic    drop_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  packet_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  assign val_o         = (count_q != '0);
  assign head_o        = mem_q[rd_ptr_q];
  assign full_thresh_o = (count_q >= THRESH_C);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i & val_o;
  assign push_ok = push_i & ((count_q < DEPTH_C) | pop_ok);
  assign drop_o  = push_i & ~push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/enoc_netemu_bridge.sv
// rtl/enoc_netemu_bridge.sv - NetEmulation to ENoC_Network bridge; ENOC_BRIDGE_STATS_EN adds per-node counters
module enoc_netemu_bridge
  import enoc_netemu_bridge_pkg::*;
#(
  parameter int X_NODES     = 4,
  parameter int Y_NODES     = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int FULL_THRESH = FIFO_DEPTH - 1,
  localparam int NODES      = X_NODES * Y_NODES
) (
  input  logic        clk,
  input  logic        rst,
  input  packet_t     pkt_in          [NODES],
  output logic        net_full        [NODES],
  output packet_t     pkt_out         [NODES],
  output packet_t     enoc_i_data     [NODES],
  output logic        enoc_i_data_val [NODES],
  input  logic        enoc_o_en       [NODES],
  input  packet_t     enoc_o_data     [NODES],
  input  logic        enoc_o_data_val [NODES],
`ifdef ENOC_BRIDGE_STATS_EN
  output logic [31:0] inj_cnt         [NODES],
  output logic [31:0] ej_cnt          [NODES],
  output logic [31:0] drop_cnt        [NODES],
`endif
  output logic        enoc_i_en       [NODES]
);

  for (genvar i = 0; i < NODES; i++) begin : g_node
    packet_t head;
    logic    val, thr, drop, pop;
    packet_t pkt_out_q, pkt_out_d;

    // The stored count may be stale until the first reset edge, so gate the handshake with rst.
    assign pop = val & ~rst & enoc_o_en[i];

    enoc_ingress_fifo #(
      .DEPTH (FIFO_DEPTH),
      .THRESH(FULL_THRESH)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (pkt_in[i].valid),
      .data_i       (pkt_in[i]),
      .pop_i        (pop),
      .head_o       (head),
      .val_o        (val),
      .full_thresh_o(thr),
      .drop_o       (drop)
    );

    assign enoc_i_data[i]     = head;
    assign enoc_i_data_val[i] = val & ~rst;
    assign net_full[i]        = thr | rst;
    assign enoc_i_en[i]       = 1'b1;

    always_comb begin
      pkt_out_d       = enoc_o_data[i];
      pkt_out_d.valid = enoc_o_data_val[i];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pkt_out_q <= '0;
      end else begin
        pkt_out_q <= pkt_out_d;
      end
    end

    assign pkt_out[i] = pkt_out_q;

`ifdef ENOC_BRIDGE_STATS_EN
    logic [31:0] inj_cnt_q, ej_cnt_q, drop_cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        inj_cnt_q  <= '0;
        ej_cnt_q   <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (pop && (inj_cnt_q != '1)) begin
          inj_cnt_q <= inj_cnt_q + 32'd1;
        end
        if (enoc_o_data_val[i] && (ej_cnt_q != '1)) begin
          ej_cnt_q <= ej_cnt_q + 32'd1;
        end
        if (drop && (drop_cnt_q != '1)) begin
          drop_cnt_q <= drop_cnt_q + 32'd1;
        end
      end
    end

    assign inj_cnt[i]  = inj_cnt_q;
    assign ej_cnt[i]   = ej_cnt_q;
    assign drop_cnt[i] = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
  end

endmodule

// File: tb/tb_enoc_netemu_bridge.sv
// tb/tb_enoc_netemu_bridge.sv - randomized and directed bench for enoc_netemu_bridge on a 3x2 mesh
`timescale 1ns/1ps
module tb_enoc_netemu_bridge;
  import enoc_netemu_bridge_pkg::*;

  localparam int XN = 3;
  localparam int YN = 2;
  localparam int N = XN * YN;
  localparam int DEPTH = 4;
  localparam int THR = 3;

  logic    clk = 1'b0;
  logic    rst;
  packet_t pkt_in [N];
  logic    net_full [N];
  packet_t pkt_out [N];
  packet_t enoc_i_data [N];
  logic    enoc_i_data_val [N];
  logic    enoc_o_en [N];
  packet_t enoc_o_data [N];
  logic    enoc_o_data_val [N];
  logic    enoc_i_en [N];
`ifdef ENOC_BRIDGE_STATS_EN
  logic [31:0] inj_cnt [N];
  logic [31:0] ej_cnt [N];
  logic [31:0] drop_cnt [N];
`endif

  int total = 0;
  int bad = 0;

  packet_t mq [N][$];
  packet_t exp_out [N];
  int      inj_m [N];
  int      ej_m [N];
  int      drop_m [N];

  always #5 clk = ~clk;

  enoc_netemu_bridge #(
    .X_NODES(XN), .Y_NODES(YN), .FIFO_DEPTH(DEPTH), .FULL_THRESH(THR)
  ) dut (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .net_full(net_full), .pkt_out(pkt_out),
    .enoc_i_data(enoc_i_data), .enoc_i_data_val(enoc_i_data_val), .enoc_o_en(enoc_o_en),
    .enoc_o_data(enoc_o_data), .enoc_o_data_val(enoc_o_data_val),
`ifdef ENOC_BRIDGE_STATS_EN
    .inj_cnt(inj_cnt), .ej_cnt(ej_cnt), .drop_cnt(drop_cnt),
`endif
    .enoc_i_en(enoc_i_en)
  );

  function automatic packet_t rand_pkt(input logic v);
    packet_t p;
    p.data   = $urandom;
    p.source = 8'($urandom);
    p.dest   = 8'($urandom);
    p.valid  = v;
    return p;
  endfunction

  // Reference: each node is an ordered queue of at most DEPTH packets; head leaves first, then arrivals.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mq[i].delete();
        exp_out[i] = '0;
        inj_m[i] = 0;
        ej_m[i] = 0;
        drop_m[i] = 0;
      end else begin
        if (mq[i].size() != 0 && enoc_o_en[i]) begin
          void'(mq[i].pop_front());
          inj_m[i]++;
        end
        if (pkt_in[i].valid) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(pkt_in[i]);
          else drop_m[i]++;
        end
        exp_out[i] = enoc_o_data[i];
        exp_out[i].valid = enoc_o_data_val[i];
        if (enoc_o_data_val[i]) ej_m[i]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    for (int i = 0; i < N; i++) begin
      pkt_in[i] = '0;
      enoc_o_en[i] = 1'b1;
      enoc_o_data[i] = '0;
      enoc_o_data_val[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < N; i++) pkt_in[i] = rand_pkt(1'b1);
    step();
    step();
    for (int i = 0; i < N; i++) begin
      total++;
      if (net_full[i] !== 1'b1) begin bad++; $display("FAIL reset_net_full node%0d got=%b exp=1", i, net_full[i]); end
      total++;
      if (enoc_i_data_val[i] !== 1'b0) begin bad++; $display("FAIL reset_val node%0d got=%b exp=0", i, enoc_i_data_val[i]); end
      total++;
      if (pkt_out[i].valid !== 1'b0) begin bad++; $display("FAIL reset_pkt_out node%0d got=%b exp=0", i, pkt_out[i].valid); end
    end
    rst = 1'b0;
    drive_idle();
    step();
    for (int i = 0; i < N; i++) begin
      total++;
      if (net_full[i] !== 1'b0) begin bad++; $display("FAIL release_net_full node%0d got=%b exp=0", i, net_full[i]); end
    end
  endtask

  task automatic test_latency();
    packet_t p;
    drive_idle();
    p = rand_pkt(1'b1);
    pkt_in[5] = p;
    #1;
    total++;
    if (enoc_i_data_val[5] !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", enoc_i_data_val[5]); end
    step();
    pkt_in[5] = '0;
    total++;
    if (enoc_i_data_val[5] !== 1'b1) begin bad++; $display("FAIL lat_val got=%b exp=1", enoc_i_data_val[5]); end
    total++;
    if (enoc_i_data[5] !== p) begin bad++; $display("FAIL lat_data got=%h exp=%h", enoc_i_data[5], p); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (enoc_i_data_val[i] !== 1'b0) begin bad++; $display("FAIL lat_idle node%0d got=%b exp=0", i, enoc_i_data_val[i]); end
    end
    step();
    total++;
    if (enoc_i_data_val[5] !== 1'b0) begin bad++; $display("FAIL lat_popped got=%b exp=0", enoc_i_data_val[5]); end
  endtask

  task automatic test_fill();
    packet_t sent [5];
    packet_t got [$];
    drive_idle();
    enoc_o_en[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sent[k] = rand_pkt(1'b1);
      pkt_in[0] = sent[k];
      step();
      total++;
      if (net_full[0] !== (k >= 2)) begin bad++; $display("FAIL fill_net_full after=%0d got=%b exp=%b", k + 1, net_full[0], (k >= 2)); end
    end
    pkt_in[0] = '0;
    total++;
    if (enoc_i_data[0] !== sent[0]) begin bad++; $display("FAIL fill_head got=%h exp=%h", enoc_i_data[0], sent[0]); end
`ifdef ENOC_BRIDGE_STATS_EN
    total++;
    if (drop_cnt[0] !== 32'd1) begin bad++; $display("FAIL fill_drop_cnt got=%0d exp=1", drop_cnt[0]); end
`endif
    enoc_o_en[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (enoc_i_data_val[0]) got.push_back(enoc_i_data[0]);
      step();
    end
    total++;
    if (got.size() !== 4) begin bad++; $display("FAIL fill_drain_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      total++;
      if (got[k] !== sent[k]) begin bad++; $display("FAIL fill_order idx%0d got=%h exp=%h", k, got[k], sent[k]); end
    end
  endtask

  task automatic test_full_pushpop();
    packet_t sent [5];
    packet_t got [$];
    drive_idle();
    enoc_o_en[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sent[k] = rand_pkt(1'b1);
      pkt_in[1] = sent[k];
      step();
    end
    sent[4] = rand_pkt(1'b1);
    pkt_in[1] = sent[4];
    enoc_o_en[1] = 1'b1;
    step();
    pkt_in[1] = '0;
    total++;
    if (net_full[1] !== 1'b1) begin bad++; $display("FAIL pp_net_full got=%b exp=1", net_full[1]); end
    total++;
    if (enoc_i_data[1] !== sent[1]) begin bad++; $display("FAIL pp_head got=%h exp=%h", enoc_i_data[1], sent[1]); end
`ifdef ENOC_BRIDGE_STATS_EN
    total++;
    if (drop_cnt[1] !== 32'd0) begin bad++; $display("FAIL pp_drop_cnt got=%0d exp=0", drop_cnt[1]); end
`endif
    for (int c = 0; c < 10; c++) begin
      if (enoc_i_data_val[1]) got.push_back(enoc_i_data[1]);
      step();
    end
    total++;
    if (got.size() !== 4) begin bad++; $display("FAIL pp_drain_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      total++;
      if (got[k] !== sent[k + 1]) begin bad++; $display("FAIL pp_order idx%0d got=%h exp=%h", k, got[k], sent[k + 1]); end
    end
  endtask

  task automatic test_stall();
    packet_t p;
    drive_idle();
    enoc_o_en[3] = 1'b0;
    p = rand_pkt(1'b1);
    pkt_in[3] = p;
    step();
    for (int c = 0; c < 3; c++) begin
      pkt_in[3] = (c < 2) ? rand_pkt(1'b1) : '0;
      step();
      total++;
      if (enoc_i_data_val[3] !== 1'b1) begin bad++; $display("FAIL stall_val cyc%0d got=%b exp=1", c, enoc_i_data_val[3]); end
      total++;
      if (enoc_i_data[3] !== p) begin bad++; $display("FAIL stall_head cyc%0d got=%h exp=%h", c, enoc_i_data[3], p); end
    end
    drive_idle();
    repeat (6) step();
  endtask

  task automatic test_egress();
    packet_t q, e;
    drive_idle();
    q = rand_pkt(1'b0);
    q.data = 32'hA5;
    enoc_o_data[2] = q;
    enoc_o_data_val[2] = 1'b1;
    #1;
    total++;
    if (pkt_out[2].valid !== 1'b0) begin bad++; $display("FAIL eg_early got=%b exp=0", pkt_out[2].valid); end
    step();
    e = q;
    e.valid = 1'b1;
    total++;
    if (pkt_out[2] !== e) begin bad++; $display("FAIL eg_pkt got=%h exp=%h", pkt_out[2], e); end
    for (int i = 0; i < N; i++) begin
      if (i != 2) begin
        total++;
        if (pkt_out[i].valid !== 1'b0) begin bad++; $display("FAIL eg_other node%0d got=%b exp=0", i, pkt_out[i].valid); end
      end
    end
`ifdef ENOC_BRIDGE_STATS_EN
    total++;
    if (ej_cnt[2] !== 32'd1) begin bad++; $display("FAIL eg_ej_cnt got=%0d exp=1", ej_cnt[2]); end
`endif
    enoc_o_data_val[2] = 1'b0;
    step();
    total++;
    if (pkt_out[2].valid !== 1'b0) begin bad++; $display("FAIL eg_clear got=%b exp=0", pkt_out[2].valid); end
  endtask

  task automatic test_midreset();
    drive_idle();
    enoc_o_en[4] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pkt_in[4] = rand_pkt(1'b1);
      step();
    end
    rst = 1'b1;
    pkt_in[4] = '0;
    step();
    rst = 1'b0;
    enoc_o_en[4] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (enoc_i_data_val[4] !== 1'b0) begin bad++; $display("FAIL midrst_val cyc%0d got=%b exp=0", c, enoc_i_data_val[4]); end
      total++;
      if (net_full[4] !== 1'b0) begin bad++; $display("FAIL midrst_full cyc%0d got=%b exp=0", c, net_full[4]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        pkt_in[i] = rand_pkt($urandom_range(0, 9) < 6);
        enoc_o_en[i] = $urandom_range(0, 1);
        enoc_o_data[i] = rand_pkt($urandom_range(0, 1));
        enoc_o_data_val[i] = $urandom_range(0, 1);
      end
      step();
      for (int i = 0; i < N; i++) begin
        total++;
        if (enoc_i_data_val[i] !== (!rst && mq[i].size() != 0)) begin
          bad++; $display("FAIL rnd_val cyc%0d node%0d got=%b exp=%b", c, i, enoc_i_data_val[i], (!rst && mq[i].size() != 0));
        end
        if (!rst && mq[i].size() != 0) begin
          total++;
          if (enoc_i_data[i] !== mq[i][0]) begin bad++; $display("FAIL rnd_head cyc%0d node%0d got=%h exp=%h", c, i, enoc_i_data[i], mq[i][0]); end
        end
        total++;
        if (net_full[i] !== (rst || mq[i].size() >= THR)) begin
          bad++; $display("FAIL rnd_full cyc%0d node%0d got=%b exp=%b", c, i, net_full[i], (rst || mq[i].size() >= THR));
        end
        total++;
        if (pkt_out[i] !== exp_out[i]) begin bad++; $display("FAIL rnd_out cyc%0d node%0d got=%h exp=%h", c, i, pkt_out[i], exp_out[i]); end
        total++;
        if (enoc_i_en[i] !== 1'b1) begin bad++; $display("FAIL rnd_i_en node%0d got=%b exp=1", i, enoc_i_en[i]); end
`ifdef ENOC_BRIDGE_STATS_EN
        total++;
        if (inj_cnt[i] !== 32'(inj_m[i])) begin bad++; $display("FAIL rnd_inj node%0d got=%0d exp=%0d", i, inj_cnt[i], inj_m[i]); end
        total++;
        if (ej_cnt[i] !== 32'(ej_m[i])) begin bad++; $display("FAIL rnd_ej node%0d got=%0d exp=%0d", i, ej_cnt[i], ej_m[i]); end
        total++;
        if (drop_cnt[i] !== 32'(drop_m[i])) begin bad++; $display("FAIL rnd_drop node%0d got=%0d exp=%0d", i, drop_cnt[i], drop_m[i]); end
`endif
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_latency();
    test_fill();
    test_full_pushpop();
    test_stall();
    test_egress();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
